// File: rtl/fetch_decode_ctrl.sv
// Fetch-side controller: owns the fetch PC, the single-outstanding imem handshake
// and the IF/ID register, reacting to hazard-unit flush/stall and branch redirects.
module fetch_decode_ctrl #(
    parameter int                   PC_WIDTH    = 32,
    parameter int                   INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
    parameter int                   PC_STEP     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flushF,
    input  logic                   flushD,
    input  logic                   stallF,
    input  logic                   stallD,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [PC_WIDTH-1:0]    pcF,
    output logic [INSTR_WIDTH-1:0] instrD,
    output logic [PC_WIDTH-1:0]    pcD,
    output logic [PC_WIDTH-1:0]    pcPlus4D,
    output logic                   validD
);

    localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

    typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD, S_DISCARD} state_t;

    state_t                   state, state_nxt;
    logic [PC_WIDTH-1:0]      pc_nxt;
    logic                     deliver;
    logic [INSTR_WIDTH-1:0]   dlv_instr;
    logic [PC_WIDTH-1:0]      dlv_pc;
    logic                     skid_load;
    logic [INSTR_WIDTH-1:0]   skid_instr;
    logic [PC_WIDTH-1:0]      skid_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_ISSUE;
            pcF   <= RESET_PC;
        end else begin
            state <= state_nxt;
            pcF   <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pcF;
        deliver   = 1'b0;
        dlv_instr = imem_rdata;
        dlv_pc    = pcF;
        skid_load = 1'b0;
        case (state)
            S_ISSUE: begin
                // A redirect while fetch is stalled still moves the PC so it is not lost.
                if (flushF) pc_nxt = branch_target;
                if (!stallF) state_nxt = flushF ? S_DISCARD : S_WAIT;
            end
            S_WAIT: begin
                if (flushF) begin
                    pc_nxt    = branch_target;
                    state_nxt = imem_rvalid ? S_ISSUE : S_DISCARD;
                end else if (imem_rvalid) begin
                    pc_nxt    = pcF + STEP;
                    deliver   = !stallD;
                    skid_load = stallD;
                    state_nxt = stallD ? S_HOLD : S_ISSUE;
                end
            end
            S_HOLD: begin
                if (flushF) begin
                    pc_nxt    = branch_target;
                    state_nxt = S_ISSUE;
                end else if (!stallD) begin
                    deliver   = 1'b1;
                    dlv_instr = skid_instr;
                    dlv_pc    = skid_pc;
                    state_nxt = S_ISSUE;
                end
            end
            S_DISCARD: begin
                if (flushF) pc_nxt = branch_target;
                if (imem_rvalid) state_nxt = S_ISSUE;
            end
            default: state_nxt = S_ISSUE;
        endcase
    end

    always_comb begin
        imem_req  = rst_n && (state == S_ISSUE) && !stallF;
        imem_addr = pcF;
    end

    // Skid buffer: only meaningful while in HOLD, so it carries no valid bit.
    always_ff @(posedge clk) begin
        if (skid_load) begin
            skid_instr <= imem_rdata;
            skid_pc    <= pcF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instrD   <= '0;
            pcD      <= '0;
            pcPlus4D <= '0;
            validD   <= 1'b0;
        end else if (flushD) begin
            validD   <= 1'b0;
        end else if (!stallD) begin
            if (deliver) begin
                instrD   <= dlv_instr;
                pcD      <= dlv_pc;
                pcPlus4D <= dlv_pc + STEP;
            end
            validD <= deliver;
        end
    end

    a_rvalid_protocol: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rvalid && ((state == S_ISSUE) || (state == S_HOLD))));

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed bench for fetch_decode_ctrl: memory responses and hazard controls are
// driven by hand each cycle and outputs compared with hand-computed values.
module tb_fetch_decode_ctrl;

    logic        clk;
    logic        rst_n;
    logic        flushF, flushD, stallF, stallD;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pcF, instrD, pcD, pcPlus4D;
    logic        validD;

    int n_checks = 0;
    int n_errors = 0;

    fetch_decode_ctrl #(
        .PC_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0), .PC_STEP(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .flushF(flushF), .flushD(flushD), .stallF(stallF), .stallD(stallD),
        .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pcF(pcF), .instrD(instrD), .pcD(pcD), .pcPlus4D(pcPlus4D), .validD(validD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in ISSUE at addr, memory answers one cycle later, checks IF/ID afterwards.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] word);
        #1;
        chk("req_issue", {31'd0, imem_req}, 32'd1);
        chk("req_addr", imem_addr, addr);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        #1;
        chk("req_wait", {31'd0, imem_req}, 32'd0);
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("validD_dlv", {31'd0, validD}, 32'd1);
        chk("instrD_dlv", instrD, word);
        chk("pcD_dlv", pcD, addr);
        chk("pcPlus4D_dlv", pcPlus4D, addr + 32'd4);
    endtask

    initial begin
        rst_n = 1'b0;
        flushF = 1'b0; flushD = 1'b0; stallF = 1'b0; stallD = 1'b0;
        branch_target = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;

        // Reset state
        #2;
        chk("rst_pcF", pcF, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_validD", {31'd0, validD}, 32'd0);
        chk("rst_instrD", instrD, 32'h0);
        chk("rst_pcD", pcD, 32'h0);
        chk("rst_pcPlus4D", pcPlus4D, 32'h0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: zero-wait stream
        fetch(32'h0, 32'h11);
        fetch(32'h4, 32'h22);
        fetch(32'h8, 32'h33);

        // Test 2: stallD on response arrival -> HOLD for 3 cycles
        tick();                          // req 0xC issued, now WAIT
        imem_rvalid = 1'b1; imem_rdata = 32'h44; stallD = 1'b1;
        #1;
        chk("t2_validD_bubble", {31'd0, validD}, 32'd0);
        tick();                          // HOLD, pcF advanced
        imem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t2_hold_req", {31'd0, imem_req}, 32'd0);
            chk("t2_hold_pcF", pcF, 32'h10);
            chk("t2_hold_instrD", instrD, 32'h33);
            tick();
        end
        stallD = 1'b0;
        tick();                          // skid delivered
        #1;
        chk("t2_instrD", instrD, 32'h44);
        chk("t2_pcD", pcD, 32'hC);
        chk("t2_pcPlus4D", pcPlus4D, 32'h10);
        chk("t2_validD", {31'd0, validD}, 32'd1);
        chk("t2_req", {31'd0, imem_req}, 32'd1);
        chk("t2_addr", imem_addr, 32'h10);

        // Test 3: flushF in WAIT, late response discarded, re-flush inside DISCARD
        tick();                          // WAIT for addr 0x10
        flushF = 1'b1; branch_target = 32'h100;
        tick();                          // DISCARD, pcF=0x100
        branch_target = 32'h180;         // flush again while still discarding
        #1;
        chk("t3_disc_req", {31'd0, imem_req}, 32'd0);
        chk("t3_disc_pcF", pcF, 32'h100);
        tick();
        flushF = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD;
        #1;
        chk("t3_reflush_pcF", pcF, 32'h180);
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("t3_dropped_validD", {31'd0, validD}, 32'd0);
        chk("t3_dropped_instrD", instrD, 32'h44);
        fetch(32'h180, 32'h55);

        // Test 4: flushF together with rvalid in WAIT -> straight back to ISSUE
        tick();                          // WAIT for addr 0x184
        flushF = 1'b1; branch_target = 32'h300;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD;
        tick();
        flushF = 1'b0; imem_rvalid = 1'b0;
        #1;
        chk("t4_validD", {31'd0, validD}, 32'd0);
        chk("t4_instrD", instrD, 32'h55);
        fetch(32'h300, 32'h66);

        // Test 5: flushD with stallD squashes validD only
        flushD = 1'b1; stallD = 1'b1;
        tick();                          // req 0x304 went out, now WAIT
        flushD = 1'b0; stallD = 1'b0;
        #1;
        chk("t5_validD", {31'd0, validD}, 32'd0);
        chk("t5_instrD", instrD, 32'h66);
        chk("t5_pcD", pcD, 32'h300);
        chk("t5_pcPlus4D", pcPlus4D, 32'h304);
        imem_rvalid = 1'b1; imem_rdata = 32'h77;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("t5_resume_instrD", instrD, 32'h77);
        chk("t5_resume_pcD", pcD, 32'h304);
        // flushD overrides a delivery: the word is lost
        tick();                          // WAIT for addr 0x308
        imem_rvalid = 1'b1; imem_rdata = 32'h88; flushD = 1'b1;
        tick();
        imem_rvalid = 1'b0; flushD = 1'b0;
        #1;
        chk("t5_lost_validD", {31'd0, validD}, 32'd0);
        chk("t5_lost_instrD", instrD, 32'h77);
        chk("t5_lost_pcF", pcF, 32'h30C);

        // Test 6: reset mid-WAIT with pcF=0x40
        tick();                          // WAIT for 0x30C
        flushF = 1'b1; branch_target = 32'h40;
        imem_rvalid = 1'b1; imem_rdata = 32'h0;
        tick();                          // ISSUE at 0x40
        flushF = 1'b0; imem_rvalid = 1'b0;
        tick();                          // WAIT at 0x40
        #1;
        chk("t6_pre_pcF", pcF, 32'h40);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_pcF", pcF, 32'h0);
        chk("t6_rst_validD", {31'd0, validD}, 32'd0);
        chk("t6_rst_instrD", instrD, 32'h0);
        chk("t6_rst_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hBEEF;   // stale response during reset
        tick();
        imem_rvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stallF = 1'b1;
        #1;
        chk("t6_stallF_req", {31'd0, imem_req}, 32'd0);
        tick();
        stallF = 1'b0;
        #1;
        chk("t6_stallF_pcF", pcF, 32'h0);
        fetch(32'h0, 32'h99);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
